// File: rtl/led_counter_alarm_pkg.sv
// ---------------------------------------------------------------------------
// led_counter_alarm_pkg
//
// Shared definitions for the button/LED counter with alarm buzzer.
//   - Button index constants for the three-bit active-low button bus.
//   - Alarm sequencer state encoding.
// ---------------------------------------------------------------------------
package led_counter_alarm_pkg;

    // Bit positions inside btn_n_i
    localparam int BTN_UP   = 0;
    localparam int BTN_DOWN = 1;
    localparam int BTN_CLR  = 2;
    localparam int NUM_BTN  = 3;

    // Alarm sequencer states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BEEP = 2'd1,
        GAP  = 2'd2,
        DONE = 2'd3
    } alarm_state_t;

endpackage : led_counter_alarm_pkg

// File: rtl/led_counter_alarm_btn_conditioner.sv
// ---------------------------------------------------------------------------
// btn_conditioner
//
// Conditions one asynchronous active-low push-button into a single-cycle
// press pulse.
//   - Two-flop synchroniser (reset to released).
//   - Debouncer: the debounced level only follows the synchronised input
//     after DEB_CYCLES consecutive differing cycles.
//   - Press pulse: one registered cycle per debounced 1->0 transition.
//
// Ports:
//   clk_i    in   system clock
//   rst_n_i  in   synchronous active-low reset
//   btn_n_i  in   raw asynchronous button, low = pressed
//   press_o  out  one-cycle pulse per debounced press
// ---------------------------------------------------------------------------
module btn_conditioner #(
    parameter int unsigned DEB_CYCLES = 2500000
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic btn_n_i,
    output logic press_o
);

    localparam int unsigned       DEB_W    = $clog2(DEB_CYCLES) + 1;
    localparam logic [DEB_W-1:0]  DEB_LAST = DEB_W'(DEB_CYCLES - 1);

    logic             sync_meta;
    logic             sync_stable;
    logic             deb_level;
    logic             deb_level_prev;
    logic [DEB_W-1:0] deb_cnt;
    logic [1:0]       sync_valid;
    logic             armed;
    logic             press_q;

    // Two-flop synchroniser; both flops reset to the released level
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            sync_meta   <= 1'b1;
            sync_stable <= 1'b1;
        end else begin
            sync_meta   <= btn_n_i;
            sync_stable <= sync_meta;
        end
    end

    // Debouncer: count consecutive cycles where the synchronised input
    // disagrees with the debounced level; flip the level once the
    // disagreement has lasted DEB_CYCLES cycles.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            deb_level <= 1'b1;
            deb_cnt   <= '0;
        end else if (sync_stable != deb_level) begin
            if (deb_cnt == DEB_LAST) begin
                deb_level <= sync_stable;
                deb_cnt   <= '0;
            end else begin
                deb_cnt <= deb_cnt + DEB_W'(1);
            end
        end else begin
            deb_cnt <= '0;
        end
    end

    // A button that is already held when reset ends must not count as a
    // press. The synchroniser flops hold their reset value for two cycles,
    // so only after those are flushed does a high sample prove the button
    // has genuinely been seen released.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            sync_valid <= 2'b00;
            armed      <= 1'b0;
        end else begin
            sync_valid <= {sync_valid[0], 1'b1};
            armed      <= armed | (sync_valid[1] & sync_stable);
        end
    end

    // Registered pulse on the debounced falling edge
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            deb_level_prev <= 1'b1;
            press_q        <= 1'b0;
        end else begin
            deb_level_prev <= deb_level;
            press_q        <= armed & deb_level_prev & ~deb_level;
        end
    end

    assign press_o = press_q;

endmodule : btn_conditioner

// File: rtl/led_counter_alarm.sv
// ---------------------------------------------------------------------------
// led_counter_alarm
//
// Board-level top: three debounced buttons step an LED_W-bit up/down
// counter shown on active-low LEDs. When the count equals ALARM_VAL an
// alarm sequencer gates a square-wave tone with an on/off beep pattern.
//
// Ports:
//   clk_i     in   system clock
//   rst_n_i   in   synchronous active-low reset
//   btn_n_i   in   [0] up, [1] down, [2] clear; async, low = pressed
//   led_n_o   out  active-low LEDs (= ~count)
//   buzzer_o  out  tone output, low outside a beep burst
//   alarm_o   out  high while count == ALARM_VAL
// ---------------------------------------------------------------------------
module led_counter_alarm
    import led_counter_alarm_pkg::*;
#(
    parameter int unsigned LED_W      = 4,
    parameter int unsigned DEB_CYCLES = 2500000,
    parameter int unsigned WRAP       = 1,
    parameter int unsigned ALARM_VAL  = (2 ** LED_W) - 1,
    parameter int unsigned TONE_HALF  = 125000,
    parameter int unsigned BEEP_ON    = 12500000,
    parameter int unsigned BEEP_OFF   = 12500000,
    parameter int unsigned BURSTS     = 0
) (
    input  logic               clk_i,
    input  logic               rst_n_i,
    input  logic [NUM_BTN-1:0] btn_n_i,
    output logic [LED_W-1:0]   led_n_o,
    output logic               buzzer_o,
    output logic               alarm_o
);

    localparam int unsigned PHASE_MAX = (BEEP_ON > BEEP_OFF) ? BEEP_ON : BEEP_OFF;
    localparam int unsigned PHASE_W   = $clog2(PHASE_MAX) + 1;
    localparam int unsigned TONE_W    = $clog2(TONE_HALF) + 1;
    localparam int unsigned BURST_W   = $clog2(BURSTS + 1) + 1;

    localparam logic [LED_W-1:0]   ALARM_CMP  = LED_W'(ALARM_VAL);
    localparam logic [LED_W-1:0]   CNT_MAX    = {LED_W{1'b1}};
    localparam logic [PHASE_W-1:0] BEEP_LAST  = PHASE_W'(BEEP_ON - 1);
    localparam logic [PHASE_W-1:0] GAP_LAST   = PHASE_W'(BEEP_OFF - 1);
    localparam logic [TONE_W-1:0]  TONE_LAST  = TONE_W'(TONE_HALF - 1);
    // Bursts still owed after the first one; unused when BURSTS == 0
    localparam logic [BURST_W-1:0] BURST_INIT = (BURSTS == 0) ? '0 : BURST_W'(BURSTS - 1);

    logic [NUM_BTN-1:0] press;
    logic [LED_W-1:0]   count_q;
    logic               alarm;

    alarm_state_t       state_q;
    alarm_state_t       state_d;
    logic [PHASE_W-1:0] phase_q;
    logic [BURST_W-1:0] burst_q;
    logic [TONE_W-1:0]  tone_cnt_q;
    logic               tone_q;
    logic               beep_entry;
    logic               gap_entry;

    // One conditioner per button
    for (genvar g = 0; g < NUM_BTN; g++) begin : g_btn
        btn_conditioner #(
            .DEB_CYCLES (DEB_CYCLES)
        ) u_cond (
            .clk_i   (clk_i),
            .rst_n_i (rst_n_i),
            .btn_n_i (btn_n_i[g]),
            .press_o (press[g])
        );
    end

    // Up/down counter: clear dominates, simultaneous up+down cancel,
    // and the bounds either wrap or saturate depending on WRAP.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            count_q <= '0;
        end else if (press[BTN_CLR]) begin
            count_q <= '0;
        end else if (press[BTN_UP] && !press[BTN_DOWN]) begin
            if ((WRAP != 0) || (count_q != CNT_MAX)) begin
                count_q <= count_q + LED_W'(1);
            end
        end else if (press[BTN_DOWN] && !press[BTN_UP]) begin
            if ((WRAP != 0) || (count_q != '0)) begin
                count_q <= count_q - LED_W'(1);
            end
        end
    end

    assign alarm = (count_q == ALARM_CMP);

    // Alarm sequencer state register
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; leaving the alarm value overrides everything
    always_comb begin
        state_d = state_q;
        if (!alarm) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: state_d = BEEP;
                BEEP: begin
                    if (phase_q == BEEP_LAST) begin
                        state_d = GAP;
                    end
                end
                GAP: begin
                    if (phase_q == GAP_LAST) begin
                        state_d = ((BURSTS == 0) || (burst_q != '0)) ? BEEP : DONE;
                    end
                end
                DONE:    state_d = DONE;
                default: state_d = IDLE;
            endcase
        end
    end

    assign beep_entry = (state_d == BEEP) && (state_q != BEEP);
    assign gap_entry  = (state_d == GAP)  && (state_q != GAP);

    // Phase counter times each BEEP/GAP interval; the burst counter holds
    // how many further bursts may still follow the current one.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            phase_q <= '0;
            burst_q <= '0;
        end else begin
            if (beep_entry || gap_entry) begin
                phase_q <= '0;
            end else if ((state_q == BEEP) || (state_q == GAP)) begin
                phase_q <= phase_q + PHASE_W'(1);
            end else begin
                phase_q <= '0;
            end

            if ((state_q == IDLE) && (state_d == BEEP)) begin
                burst_q <= BURST_INIT;
            end else if ((state_q == GAP) && (state_d == BEEP) && (burst_q != '0)) begin
                burst_q <= burst_q - BURST_W'(1);
            end
        end
    end

    // Tone generator restarts low on every burst entry and is held low
    // whenever the sequencer is not (or will not be) beeping.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            tone_cnt_q <= '0;
            tone_q     <= 1'b0;
        end else if (beep_entry) begin
            tone_cnt_q <= '0;
            tone_q     <= 1'b0;
        end else if ((state_q == BEEP) && (state_d == BEEP)) begin
            if (tone_cnt_q == TONE_LAST) begin
                tone_cnt_q <= '0;
                tone_q     <= ~tone_q;
            end else begin
                tone_cnt_q <= tone_cnt_q + TONE_W'(1);
            end
        end else begin
            tone_cnt_q <= '0;
            tone_q     <= 1'b0;
        end
    end

    // Outputs
    always_comb begin
        led_n_o  = ~count_q;
        buzzer_o = tone_q & (state_q == BEEP);
        alarm_o  = alarm;
    end

endmodule : led_counter_alarm

// File: tb/tb_led_counter_alarm.sv
// ---------------------------------------------------------------------------
// tb_led_counter_alarm
//
// Two instances share one clock: dut_a wraps and gives two bursts per
// alarm, dut_b saturates and beeps continuously. A sample-history model
// predicts count, alarm and buzzer from the button levels seen at each
// rising edge; every falling edge compares both instances against it.
// ---------------------------------------------------------------------------
module tb_led_counter_alarm;

    localparam int LED_W  = 4;
    localparam int DEB    = 4;
    localparam int TONE   = 3;
    localparam int B_ON   = 12;
    localparam int B_OFF  = 6;
    localparam int ALARM  = 15;
    localparam int PERIOD = B_ON + B_OFF;
    localparam int LAT    = 4;   // edges from debounce decision to count update

    logic             clk = 1'b0;
    logic             rst_n [2];
    logic [2:0]       btn_n [2];
    logic [LED_W-1:0] led_n [2];
    logic             buz   [2];
    logic             alm   [2];

    always #5 clk = ~clk;

    led_counter_alarm #(
        .LED_W(LED_W), .DEB_CYCLES(DEB), .WRAP(1), .ALARM_VAL(ALARM),
        .TONE_HALF(TONE), .BEEP_ON(B_ON), .BEEP_OFF(B_OFF), .BURSTS(2)
    ) dut_a (
        .clk_i(clk), .rst_n_i(rst_n[0]), .btn_n_i(btn_n[0]),
        .led_n_o(led_n[0]), .buzzer_o(buz[0]), .alarm_o(alm[0])
    );

    led_counter_alarm #(
        .LED_W(LED_W), .DEB_CYCLES(DEB), .WRAP(0), .ALARM_VAL(ALARM),
        .TONE_HALF(TONE), .BEEP_ON(B_ON), .BEEP_OFF(B_OFF), .BURSTS(0)
    ) dut_b (
        .clk_i(clk), .rst_n_i(rst_n[1]), .btn_n_i(btn_n[1]),
        .led_n_o(led_n[1]), .buzzer_o(buz[1]), .alarm_o(alm[1])
    );

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    // Model state
    int wrap_m   [2] = '{1, 0};
    int bursts_m [2] = '{2, 0};
    int m_cnt    [2];
    int m_age    [2];          // consecutive edges seen with count at ALARM
    int m_run    [2][3];
    bit m_level  [2][3];
    bit m_armed  [2][3];
    int m_due    [2][3];
    bit fire     [3];
    bit smp;

    task automatic checkOutput(input string name, input int actual, input int expected);
        n_checks++;
        if (actual != expected) begin
            n_fail++;
            $display("[TB] FAIL %s at %0t: got %0d, expected %0d", name, $time, actual, expected);
        end
    endtask

    // Expected buzzer from time spent at the alarm value
    function automatic int expBuzzer(input int age, input int bursts);
        int j, o;
        if (age == 0) return 0;
        j = age - 1;
        o = j % PERIOD;
        if (bursts != 0 && (j / PERIOD) >= bursts) return 0;
        if (o >= B_ON) return 0;
        return ((o / TONE) % 2 == 1) ? 1 : 0;
    endfunction

    // Behavioural model, advanced at every rising edge
    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (!rst_n[d]) begin
                m_cnt[d] = 0;
                m_age[d] = 0;
                for (int b = 0; b < 3; b++) begin
                    m_run[d][b]   = 0;
                    m_level[d][b] = 1'b1;
                    m_armed[d][b] = 1'b0;
                    m_due[d][b]   = 0;
                end
            end else begin
                if (m_cnt[d] == ALARM) m_age[d]++;
                else m_age[d] = 0;

                for (int b = 0; b < 3; b++) begin
                    fire[b] = 1'b0;
                    if (m_due[d][b] > 0) begin
                        m_due[d][b]--;
                        if (m_due[d][b] == 0) fire[b] = 1'b1;
                    end
                end

                if (fire[2]) begin
                    m_cnt[d] = 0;
                end else if (fire[0] && !fire[1]) begin
                    if (wrap_m[d] != 0) m_cnt[d] = (m_cnt[d] + 1) % 16;
                    else if (m_cnt[d] < 15) m_cnt[d] = m_cnt[d] + 1;
                end else if (fire[1] && !fire[0]) begin
                    if (wrap_m[d] != 0) m_cnt[d] = (m_cnt[d] + 15) % 16;
                    else if (m_cnt[d] > 0) m_cnt[d] = m_cnt[d] - 1;
                end

                for (int b = 0; b < 3; b++) begin
                    smp = btn_n[d][b];
                    if (smp != m_level[d][b]) begin
                        m_run[d][b]++;
                        if (m_run[d][b] == DEB) begin
                            m_level[d][b] = smp;
                            m_run[d][b]   = 0;
                            if (!smp && m_armed[d][b]) m_due[d][b] = LAT;
                        end
                    end else begin
                        m_run[d][b] = 0;
                    end
                    if (smp) m_armed[d][b] = 1'b1;
                end
            end
        end
    end

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        if (chk_en) begin
            for (int d = 0; d < 2; d++) begin
                checkOutput(d == 0 ? "led_a" : "led_b", int'(led_n[d]), 15 - m_cnt[d]);
                checkOutput(d == 0 ? "alarm_a" : "alarm_b", int'(alm[d]), (m_cnt[d] == ALARM) ? 1 : 0);
                checkOutput(d == 0 ? "buzzer_a" : "buzzer_b", int'(buz[d]), expBuzzer(m_age[d], bursts_m[d]));
            end
        end
    end

    // Press the buttons in mask (1 = pressed) for hold edges, then release
    task automatic applyStimulus(input int d, input logic [2:0] mask, input int hold, input int gap);
        @(posedge clk);
        #2 btn_n[d] = ~mask;
        repeat (hold) @(posedge clk);
        #2 btn_n[d] = 3'b111;
        repeat (gap) @(posedge clk);
    endtask

    // Wait (bounded) until the model says we are 'phase' cycles into a period
    task automatic waitPhase(input int d, input int phase);
        bit found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            @(posedge clk);
            #1;
            if (m_age[d] > 0 && ((m_age[d] - 1) % PERIOD) == phase) found = 1'b1;
        end
        n_checks++;
        if (!found) begin
            n_fail++;
            $display("[TB] FAIL wait_phase: burst phase %0d not reached within 100 cycles", phase);
        end
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        rst_n[0] = 1'b0; rst_n[1] = 1'b0;
        btn_n[0] = 3'b111; btn_n[1] = 3'b111;
        @(posedge clk);
        #1 chk_en = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_led_a", int'(led_n[0]), 15);
        checkOutput("rst_buz_a", int'(buz[0]), 0);
        checkOutput("rst_alarm_a", int'(alm[0]), 0);
        #1 rst_n[0] = 1'b1; rst_n[1] = 1'b1;
        repeat (5) @(posedge clk);

        // First press with exact latency: 8th edge after the input falls
        @(posedge clk);
        #2 btn_n[0] = 3'b110;
        repeat (7) @(posedge clk);
        #1 checkOutput("latency_before_a", int'(led_n[0]), 4'b1111);
        @(posedge clk);
        #1 checkOutput("latency_at_a", int'(led_n[0]), 4'b1110);
        repeat (12) @(posedge clk);
        #2 btn_n[0] = 3'b111;
        repeat (20) @(posedge clk);

        applyStimulus(0, 3'b001, 20, 20);
        #1 checkOutput("press2_a", int'(led_n[0]), 4'b1101);
        applyStimulus(0, 3'b001, 20, 20);
        #1 checkOutput("press3_a", int'(led_n[0]), 4'b1100);

        // Short glitch, simultaneous up+down, clear with up
        applyStimulus(0, 3'b001, 3, 20);
        #1 checkOutput("glitch_a", int'(led_n[0]), 4'b1100);
        applyStimulus(0, 3'b011, 20, 20);
        #1 checkOutput("updown_a", int'(led_n[0]), 4'b1100);
        applyStimulus(0, 3'b101, 20, 20);
        #1 checkOutput("clear_a", int'(led_n[0]), 4'b1111);

        // Wrap 0 -> 15 arms the alarm; two bursts then silence
        applyStimulus(0, 3'b010, 20, 20);
        #1 checkOutput("wrap_down_a", int'(led_n[0]), 4'b0000);
        checkOutput("alarm_on_a", int'(alm[0]), 1);
        repeat (30) @(posedge clk);
        #1 checkOutput("done_silent_a", int'(buz[0]), 0);

        // Leave and return to re-arm, then wrap 15 -> 0
        applyStimulus(0, 3'b010, 20, 20);
        applyStimulus(0, 3'b001, 20, 40);
        applyStimulus(0, 3'b001, 20, 20);
        #1 checkOutput("wrap_up_a", int'(led_n[0]), 4'b1111);

        // Button held through reset gives no press until re-pressed
        @(posedge clk);
        #2 btn_n[0] = 3'b110; rst_n[0] = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst_n[0] = 1'b1;
        repeat (20) @(posedge clk);
        #1 checkOutput("held_rst_a", int'(led_n[0]), 4'b1111);
        #1 btn_n[0] = 3'b111;
        repeat (20) @(posedge clk);
        applyStimulus(0, 3'b001, 20, 20);
        #1 checkOutput("repress_a", int'(led_n[0]), 4'b1110);

        // Saturating instance: floor, count up to 15, ceiling
        applyStimulus(1, 3'b010, 20, 20);
        #1 checkOutput("sat_low_b", int'(led_n[1]), 4'b1111);
        for (int i = 0; i < 15; i++) applyStimulus(1, 3'b001, 8, 8);
        #1 checkOutput("reach15_b", int'(led_n[1]), 4'b0000);
        repeat (80) @(posedge clk);
        applyStimulus(1, 3'b001, 20, 20);
        #1 checkOutput("sat_high_b", int'(led_n[1]), 4'b0000);

        // Down press landing while the tone is high
        waitPhase(1, 2);
        #1 btn_n[1] = 3'b101;
        repeat (7) @(posedge clk);
        #1 checkOutput("pre_drop_alarm_b", int'(alm[1]), 1);
        @(posedge clk);
        #1;
        checkOutput("drop_alarm_b", int'(alm[1]), 0);
        checkOutput("drop_buz_b", int'(buz[1]), 1);
        checkOutput("drop_led_b", int'(led_n[1]), 4'b0001);
        @(posedge clk);
        #1 checkOutput("silenced_b", int'(buz[1]), 0);
        repeat (11) @(posedge clk);
        #2 btn_n[1] = 3'b111;
        repeat (20) @(posedge clk);

        // Reset in the middle of a burst
        applyStimulus(1, 3'b001, 20, 20);
        waitPhase(1, 5);
        checkOutput("pre_rst_buz_b", int'(buz[1]), 1);
        #1 rst_n[1] = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("rst_led_b", int'(led_n[1]), 4'b1111);
        checkOutput("rst_buz_b", int'(buz[1]), 0);
        checkOutput("rst_alarm_b", int'(alm[1]), 0);
        #1 rst_n[1] = 1'b1;
        repeat (10) @(posedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_led_counter_alarm

// File: doc/led_counter_alarm.md
# led_counter_alarm

Parametrised button-driven LED counter with a patterned alarm buzzer, intended as the board-level top for the button/LED exercises. Three active-low asynchronous push-buttons are synchronised, debounced and edge-detected. The resulting press events step an LED_W-bit up/down counter, which drives active-low LEDs. When the counter reaches a programmable alarm value, a square-wave tone is gated by an on/off beep pattern.

## Interface
Parameters:
- LED_W, 4, counter and LED width (1..16)
- DEB_CYCLES, 2500000, consecutive stable cycles before a debounced level changes (≥2)
- WRAP, 1, 1 = counter wraps modulo 2^LED_W; 0 = counter saturates at 0 and 2^LED_W-1
- ALARM_VAL, 2^LED_W-1, counter value that arms the alarm
- TONE_HALF, 125000, tone half-period in clock cycles (≥1)
- BEEP_ON, 12500000, cycles the tone is enabled per burst
- BEEP_OFF, 12500000, silent cycles between bursts
- BURSTS, 0, number of bursts per alarm event; 0 = continuous

Ports:
- clk_i  in  1  single system clock
- rst_n_i  in  1  synchronous, active-low reset
- btn_n_i  in  3  async active-low buttons: [0] up, [1] down, [2] clear
- led_n_o  out  LED_W  active-low LEDs, equal to ~count
- buzzer_o  out  1  tone output
- alarm_o  out  1  high while count == ALARM_VAL

## Operation
- Conditioning, per button:
  - Two-flop synchroniser.
  - Debouncer: a counter increments each cycle the synchronised value differs from the debounced level and clears whenever they match. On the cycle it reaches DEB_CYCLES-1 while still differing, the debounced level toggles on the next edge and the counter clears.
  - Press pulse: registered, one cycle wide, asserted on each debounced 1→0 transition. Releases generate nothing.
- Counter priority:
  - clear → 0.
  - Otherwise up and down in the same cycle → no change.
  - Otherwise up → +1, down → -1.
  - WRAP=1: wraps modulo 2^LED_W. WRAP=0: holds at the bounds.
- Alarm FSM states: IDLE, BEEP, GAP, DONE.
  - IDLE→BEEP when count == ALARM_VAL. The phase counter and burst counter load.
  - BEEP lasts exactly BEEP_ON cycles, then →GAP. The tone runs.
  - GAP lasts BEEP_OFF cycles. It then goes →BEEP if BURSTS==0 or bursts remain, otherwise →DONE.
  - DONE holds silent until count != ALARM_VAL, then →IDLE. Re-arming requires the count to leave and return to ALARM_VAL.
  - Any state →IDLE when count != ALARM_VAL. This takes priority over other transitions and silences the buzzer on the next edge.
- Tone: buzzer_o toggles every TONE_HALF cycles while in BEEP. The tone counter restarts at each BEEP entry, so buzzer_o is 0 at the start of every burst. buzzer_o is forced to 0 outside BEEP.

## Timing
- Reset values:
  - count=0, so led_n_o all 1.
  - buzzer_o=0, alarm_o = (ALARM_VAL==0).
  - Debounced levels = 1 (released); synchroniser flops = 1.
  - All counters = 0; FSM = IDLE.
- Reset mid-operation: everything returns to the reset state on the next edge. A button held through reset produces one press only after it is released and pressed again.
- Press latency: led_n_o changes exactly DEB_CYCLES+4 edges after the first edge at which btn_n_i is sampled low, provided the input is held. The stages are sync (2), debounce (DEB_CYCLES), pulse (1) and counter (1).
- Glitches: a glitch shorter than DEB_CYCLES synchronised cycles produces no press.
- alarm_o is combinational from count.
- The FSM enters BEEP one edge after count first equals ALARM_VAL.
- Width rule: the debounce, phase and tone counters are each sized by $clog2 of their parameter plus 1. There is no overflow at the maximum parameter values.

## Structure
- Package led_counter_alarm_pkg holds:
  - Button index constants BTN_UP=0, BTN_DOWN=1, BTN_CLR=2, and NUM_BTN=3.
  - The alarm state enum alarm_state_t.
- Sub-module btn_conditioner (synchroniser + debouncer + press pulse, parameter DEB_CYCLES), instantiated once per button in a generate loop.
- Counter, alarm FSM and tone generator live in the top.

## Test plan
Bench parameters: LED_W=4, DEB_CYCLES=4, TONE_HALF=3, BEEP_ON=12, BEEP_OFF=6.
- Reset, then press up 3 times with 20-cycle holds and gaps → led_n_o 4'b1110, 1101, 1100. Each change occurs exactly 8 edges after the falling input sample.
- 3-cycle low glitch on up → no change. Up and down pressed together → no change. Clear with up active → count 0.
- WRAP=1: from 15, press up → 0. WRAP=0: from 15, press up → stays 15; from 0, press down → stays 0.
- Count reaches 15 with BURSTS=2 → buzzer_o toggles every 3 cycles for 12 cycles, is silent for 6, runs a second 12-cycle burst, then stays silent in DONE. Press down then up → the bursts repeat.
- BURSTS=0, alarm active → bursts repeat indefinitely. Press down mid-BEEP → buzzer_o is 0 the next cycle and alarm_o drops.
- Assert rst_n_i mid-BEEP with count=15 → next edge gives led_n_o=4'b1111, buzzer_o=0, alarm_o=0.
